uart_fifo_core: RTL and testbench

//  Parametrised successor UART: full-duplex serial TX/RX with TX and RX FIFOs and a runtime baud divisor.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_fifo_core_if.sv | 8 +
 rtl/uart_sync_fifo.sv | 36 +++
 rtl/uart_fifo_core.sv | 170 +++++++++++++++++
 tb/tb_uart_fifo_core.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register map, status/control bit indices, FSM state types and divisor clamp for uart_fifo_core
package uart_pkg;
  localparam logic [2:0] A_RXDATA = 3'd0, A_TXDATA = 3'd1, A_STATUS = 3'd2, A_CONTROL = 3'd3, A_DIVISOR = 3'd4;
  localparam int S_RXNE = 0, S_TXNF = 1, S_TXIDLE = 2, S_RXOVR = 3, S_FRERR = 4, S_PERR = 5, S_TXOVF = 6;
  localparam int C_IE_RX = 0, C_IE_TX = 1, C_IE_ERR = 2, C_PAR_EN = 3, C_PAR_ODD = 4;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return d < 16'd3 ? 16'd3 : d;
  endfunction
endpackage

// File: rtl/uart_fifo_core_if.sv
// uart_fifo_core_if: memory-mapped slave bus between CPU and uart_fifo_core
interface uart_fifo_core_if;
  logic [2:0] address;
  logic chipselect, read_n, write_n;
  logic [15:0] writedata, readdata;
  modport master(output address, chipselect, read_n, write_n, writedata, input readdata);
  modport slave(input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO, pushes when full and pops when empty are ignored
module uart_sync_fifo #(parameter int WIDTH = 8, parameter int DEPTH = 16) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  // storage write
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers and occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: FIFO-buffered full-duplex UART with runtime divisor and masked irq; parity via UART_PARITY_EN
module uart_fifo_core import uart_pkg::*; #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DEFAULT_DIV = 433
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic uart_rxd,
  output logic uart_txd,
  output logic int_irq,
  uart_fifo_core_if.slave bus
);
`ifdef UART_PARITY_EN
  localparam logic [4:0] CTRL_MASK = 5'h1f;
`else
  localparam logic [4:0] CTRL_MASK = 5'h07;
`endif
  localparam logic [2:0] LAST = 3'(DATA_BITS-1);
  logic rd, wr, st_wr;
  logic [4:0] control;
  logic [15:0] divisor, rdata;
  logic rxovr, frerr, perr, txovf;
  logic [6:0] status;
  logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] tx_dout, rx_dout;
  tx_state_t tx_st;
  logic [15:0] tx_div, tx_cnt;
  logic [DATA_BITS-1:0] tx_sh;
  logic [2:0] tx_bit;
  logic tx_par, tx_pen, tx_stop, tx_tick;
  rx_state_t rx_st;
  logic [15:0] rx_div, rx_cnt, rx_hend;
  logic [DATA_BITS-1:0] rx_sh;
  logic [2:0] rx_bit;
  logic rx_pen, rx_odd, rx_perr, rx_tick, s1, s2, s3;
  assign rd = bus.chipselect & !bus.read_n;
  assign wr = bus.chipselect & !bus.write_n;
  assign st_wr = wr & bus.address == A_STATUS;
  assign tx_push = wr & bus.address == A_TXDATA;
  assign tx_pop = tx_st == TX_IDLE & !tx_empty;
  assign rx_pop = rd & bus.address == A_RXDATA;
  assign rx_push = rx_st == RX_STOP & rx_tick;
  assign tx_tick = tx_cnt == tx_div;
  assign rx_hend = (rx_div - 16'd1) >> 1;
  assign rx_tick = rx_cnt == (rx_st == RX_START ? rx_hend : rx_div);
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk_clk), .rst(reset_reset), .push(tx_push), .pop(tx_pop),
    .din(bus.writedata[DATA_BITS-1:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk_clk), .rst(reset_reset), .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  // live status word
  always_comb begin
    status = '0;
    status[S_RXNE] = !rx_empty;
    status[S_TXNF] = !tx_full;
    status[S_TXIDLE] = tx_empty & tx_st == TX_IDLE;
    status[S_RXOVR] = rxovr;
    status[S_FRERR] = frerr;
    status[S_PERR] = perr;
    status[S_TXOVF] = txovf;
  end
  assign rdata = bus.address == A_RXDATA ? 16'(rx_dout & {DATA_BITS{!rx_empty}}) :
                 bus.address == A_STATUS ? {9'd0, status} :
                 bus.address == A_CONTROL ? {11'd0, control} :
                 bus.address == A_DIVISOR ? divisor : 16'd0;
  // registers, sticky flags, read data and interrupt
  always_ff @(posedge clk_clk)
    if (reset_reset) begin
      control <= '0;
      divisor <= 16'(DEFAULT_DIV);
      {rxovr, frerr, perr, txovf} <= '0;
      bus.readdata <= '0;
      int_irq <= 1'b0;
    end else begin
      if (wr & bus.address == A_CONTROL) control <= bus.writedata[4:0] & CTRL_MASK;
      if (wr & bus.address == A_DIVISOR) divisor <= clamp_div(bus.writedata);
      rxovr <= rxovr & !(st_wr & bus.writedata[S_RXOVR]) | rx_push & rx_full;
      frerr <= frerr & !(st_wr & bus.writedata[S_FRERR]) | rx_push & !s2;
      perr <= perr & !(st_wr & bus.writedata[S_PERR]) | rx_push & rx_perr;
      txovf <= txovf & !(st_wr & bus.writedata[S_TXOVF]) | tx_push & tx_full;
      if (rd) bus.readdata <= rdata;
      int_irq <= control[C_IE_RX] & status[S_RXNE] | control[C_IE_TX] & status[S_TXIDLE] | control[C_IE_ERR] & |status[S_TXOVF:S_RXOVR];
    end
  // transmit FSM: frame parameters latched when an entry is popped
  always_ff @(posedge clk_clk)
    if (reset_reset) begin
      tx_st <= TX_IDLE;
      uart_txd <= 1'b1;
      {tx_div, tx_cnt, tx_sh, tx_bit, tx_par, tx_pen, tx_stop} <= '0;
    end else if (tx_st == TX_IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_stop <= 1'b0;
      if (!tx_empty) begin
        tx_st <= TX_START;
        uart_txd <= 1'b0;
        tx_sh <= tx_dout;
        tx_div <= divisor;
        tx_par <= ^tx_dout ^ control[C_PAR_ODD];
        tx_pen <= control[C_PAR_EN];
      end
    end else if (!tx_tick) tx_cnt <= tx_cnt + 16'd1;
    else begin
      tx_cnt <= '0;
      case (tx_st)
        TX_START: begin
          tx_st <= TX_DATA;
          uart_txd <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
        TX_DATA: if (tx_bit == LAST) begin
          tx_st <= tx_pen ? TX_PARITY : TX_STOP;
          uart_txd <= tx_pen ? tx_par : 1'b1;
        end else begin
          tx_bit <= tx_bit + 3'd1;
          uart_txd <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
        TX_PARITY: begin
          tx_st <= TX_STOP;
          uart_txd <= 1'b1;
        end
        default: begin
          tx_st <= tx_stop == 1'(STOP_BITS-1) ? TX_IDLE : TX_STOP;
          tx_stop <= 1'b1;
        end
      endcase
    end
  // rxd synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk_clk)
    if (reset_reset) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {uart_rxd, s1, s2};
  // receive FSM: half-bit start qualification, then mid-bit sampling
  always_ff @(posedge clk_clk)
    if (reset_reset) begin
      rx_st <= RX_IDLE;
      {rx_div, rx_cnt, rx_sh, rx_bit, rx_pen, rx_odd, rx_perr} <= '0;
    end else if (rx_st == RX_IDLE) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_perr <= 1'b0;
      if (s3 & !s2) begin
        rx_st <= RX_START;
        rx_div <= divisor;
        rx_pen <= control[C_PAR_EN];
        rx_odd <= control[C_PAR_ODD];
      end
    end else if (!rx_tick) rx_cnt <= rx_cnt + 16'd1;
    else begin
      rx_cnt <= '0;
      case (rx_st)
        RX_START: rx_st <= s2 ? RX_IDLE : RX_DATA;
        RX_DATA: begin
          rx_sh <= {s2, rx_sh[DATA_BITS-1:1]};
          rx_bit <= rx_bit + 3'd1;
          rx_st <= rx_bit == LAST ? (rx_pen ? RX_PARITY : RX_STOP) : RX_DATA;
        end
        RX_PARITY: begin
          rx_perr <= s2 != (^rx_sh ^ rx_odd);
          rx_st <= RX_STOP;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: scoreboard bench with directed register, serial, loopback, error and irq vectors
module tb_uart_fifo_core;
  import uart_pkg::*;
  logic clk = 0, rst = 1, rxd_drv = 1, loop = 0, rd_q = 0;
  logic txd, irq, rxd;
  int n_cmp = 0, n_bad = 0, bl = 434;
  bit tx_pe = 0;
  typedef struct {string name; logic [15:0] v;} rexp_t;
  typedef struct {logic [7:0] b; logic p;} texp_t;
  rexp_t rq[$];
  texp_t tq[$];
  uart_fifo_core_if bus();
  assign rxd = loop ? txd : rxd_drv;
  uart_fifo_core dut (.clk_clk(clk), .reset_reset(rst), .uart_rxd(rxd), .uart_txd(txd), .int_irq(irq), .bus(bus));
  always #5 clk = ~clk;
  function automatic void check(string name, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endfunction
  always @(posedge clk) rd_q <= bus.chipselect & !bus.read_n;
  initial forever begin
    rexp_t e;
    @(negedge clk);
    if (rd_q) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got 0x%h, expected no read", bus.readdata);
      end else begin
        e = rq.pop_front();
        check(e.name, bus.readdata, e.v);
      end
    end
  end
  initial forever begin
    logic [7:0] b;
    logic p, s;
    texp_t e;
    @(negedge txd);
    if (!rst) begin
      repeat (bl / 2) @(negedge clk);
      if (txd === 1'b0) begin
        b = 0;
        p = 0;
        for (int i = 0; i < 8; i++) begin
          repeat (bl) @(negedge clk);
          b[i] = txd;
        end
        if (tx_pe) begin
          repeat (bl) @(negedge clk);
          p = txd;
        end
        repeat (bl) @(negedge clk);
        s = txd;
        if (tq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_tx_frame: got 0x%h, expected none", b);
        end else begin
          e = tq.pop_front();
          check("tx_byte", 16'(b), 16'(e.b));
          if (tx_pe) check("tx_parity", 16'(p), 16'(e.p));
        end
        check("tx_stop", 16'(s), 16'd1);
      end
    end
  end
  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1;
    bus.write_n = 0;
    @(negedge clk);
    bus.chipselect = 0;
    bus.write_n = 1;
  endtask
  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
    @(negedge clk);
    bus.address = a;
    bus.chipselect = 1;
    bus.read_n = 0;
    rq.push_back('{n, e});
    @(negedge clk);
    bus.chipselect = 0;
    bus.read_n = 1;
  endtask
  task automatic tx(input logic [7:0] b, input logic p);
    tq.push_back('{b, p});
    wr(A_TXDATA, {8'd0, b});
  endtask
  task automatic setdiv(input int d);
    wr(A_DIVISOR, 16'(d));
    bl = d + 1;
  endtask
  task automatic send_rx(input logic [7:0] b, input logic p, input bit pe, input logic s);
    rxd_drv = 0;
    wait_clk(bl);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      wait_clk(bl);
    end
    if (pe) begin
      rxd_drv = p;
      wait_clk(bl);
    end
    rxd_drv = s;
    wait_clk(bl);
    rxd_drv = 1;
    wait_clk(bl);
  endtask
  initial begin
    bus.address = 0;
    bus.chipselect = 0;
    bus.read_n = 1;
    bus.write_n = 1;
    bus.writedata = 0;
    wait_clk(3);
    check("rst_readdata", bus.readdata, 16'h0000);
    check("rst_txd", 16'(txd), 16'd1);
    check("rst_irq", 16'(irq), 16'd0);
    rst = 0;
    rd(A_STATUS, 16'h0006, "rst_status");
    rd(A_DIVISOR, 16'd433, "rst_divisor");
    rd(A_CONTROL, 16'h0000, "rst_control");
    rd(A_RXDATA, 16'h0000, "rx_empty_read");
    wr(A_DIVISOR, 16'd1);
    rd(A_DIVISOR, 16'd3, "div_clamp");
    setdiv(7);
    rd(A_DIVISOR, 16'd7, "div7");
    tx(8'hA5, 0);
    wait_clk(100);
    rd(A_STATUS, 16'h0006, "txidle_after_a5");
    loop = 1;
    tx(8'h00, 0);
    tx(8'hFF, 0);
    tx(8'h3C, 0);
    wait_clk(300);
    rd(A_STATUS, 16'h0007, "loop_rxne");
    rd(A_RXDATA, 16'h0000, "loop_rx0");
    rd(A_RXDATA, 16'h00FF, "loop_rx1");
    rd(A_RXDATA, 16'h003C, "loop_rx2");
    rd(A_STATUS, 16'h0006, "loop_rxne_clear");
    loop = 0;
    for (int i = 0; i < 17; i++) tx(8'h80 + 8'(i), 0);
    wait_clk(1500);
    rd(A_STATUS, 16'h0006, "tx17_no_ovf");
    for (int i = 0; i < 17; i++) tx(8'h60 + 8'(i), 0);
    wr(A_TXDATA, 16'h00EE);
    rd(A_STATUS, 16'h0040, "txovf_set");
    wr(A_STATUS, 16'h0040);
    rd(A_STATUS, 16'h0000, "txovf_clear");
    wait_clk(1500);
    rd(A_STATUS, 16'h0006, "tx_drain");
    setdiv(15);
    rxd_drv = 0;
    wait_clk(4);
    rxd_drv = 1;
    wait_clk(300);
    rd(A_STATUS, 16'h0006, "glitch_no_byte");
    send_rx(8'h5A, 0, 0, 0);
    wait_clk(4);
    rd(A_STATUS, 16'h0017, "frerr_set");
    wr(A_CONTROL, 16'h0004);
    wait_clk(3);
    check("irq_err", 16'(irq), 16'd1);
    rd(A_RXDATA, 16'h005A, "frerr_byte");
    wr(A_STATUS, 16'h0010);
    wait_clk(3);
    check("irq_err_clear", 16'(irq), 16'd0);
    rd(A_STATUS, 16'h0006, "frerr_clear");
    wr(A_CONTROL, 16'h0002);
    wait_clk(3);
    check("irq_tx", 16'(irq), 16'd1);
    wr(A_CONTROL, 16'h0000);
    wait_clk(3);
    check("irq_off", 16'(irq), 16'd0);
    wr(A_CONTROL, 16'hFFFF);
`ifdef UART_PARITY_EN
    rd(A_CONTROL, 16'h001F, "control_mask");
`else
    rd(A_CONTROL, 16'h0007, "control_mask");
`endif
    wr(A_CONTROL, 16'h0000);
    for (int i = 0; i < 17; i++) send_rx(8'h10 + 8'(i), 0, 0, 1);
    wait_clk(4);
    rd(A_STATUS, 16'h000F, "rxovr_set");
    for (int i = 0; i < 16; i++) rd(A_RXDATA, 16'h0010 + 16'(i), "rxovr_byte");
    rd(A_STATUS, 16'h000E, "rxovr_sticky");
    wr(A_STATUS, 16'h0008);
    rd(A_STATUS, 16'h0006, "rxovr_clear");
`ifdef UART_PARITY_EN
    setdiv(7);
    wr(A_CONTROL, 16'h0008);
    tx_pe = 1;
    loop = 1;
    tx(8'h07, 1);
    wait_clk(200);
    rd(A_STATUS, 16'h0007, "par_ok");
    rd(A_RXDATA, 16'h0007, "par_byte");
    loop = 0;
    send_rx(8'h07, 0, 1, 1);
    wait_clk(4);
    rd(A_STATUS, 16'h0027, "perr_set");
    wr(A_CONTROL, 16'h000C);
    wait_clk(3);
    check("irq_perr", 16'(irq), 16'd1);
    rd(A_RXDATA, 16'h0007, "perr_byte");
    wr(A_STATUS, 16'h0020);
    rd(A_STATUS, 16'h0006, "perr_clear");
    wr(A_CONTROL, 16'h0000);
    tx_pe = 0;
`endif
    wait_clk(10);
    check("tx_queue_drained", 16'(tq.size()), 16'd0);
    check("rd_queue_drained", 16'(rq.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
